// File: rtl/tlv5614_frame_serializer.sv
// TLV5614 quad-DAC frame serializer: collects per-channel requests, arbitrates
// round-robin and shifts 16-bit frames out over SCLK/DIN/FS/CS.
module tlv5614_frame_serializer #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [3:0]  CH_TrSgn,
  input  logic [63:0] CH_Data,
  output logic        UpdateDone,
  output logic [1:0]  Done_Ch,
  output logic        Busy,
  output logic [3:0]  Overrun,
  output logic        DAC_CLK,
  output logic        DAC_DIN,
  output logic        DAC_FS,
  output logic        DAC_CS,
  output logic        DAC_LDAC,
  output logic        DAC_PD
);

  localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned BIT_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [BIT_W-1:0]    bit_idx, bit_n;
  logic                low_phase, low_phase_n;
  logic [WORD_W-1:0]   sreg, sreg_n;
  logic [1:0]          last, last_n;
  logic [3:0]          pending, pending_n;
  logic [3:0]          trig_q;
  logic [3:0]          rise;
  logic [3:0]          grant_clr;
  logic [WORD_W-1:0]   shadow [4];
  logic                found;
  logic [1:0]          grant;
  logic [1:0]          idx;
  logic                fs_n, cs_n, sclk_n, din_n, done_n, busy_n;

  assign DAC_LDAC = 1'b0;
  assign DAC_PD   = 1'b1;

  // Rising-edge detect on the channel triggers
  always_comb begin
    rise = CH_TrSgn & ~trig_q;
  end

  // Next-state, counters, arbitration and next values of the registered outputs
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_n       = bit_idx;
    low_phase_n = low_phase;
    sreg_n      = sreg;
    last_n      = last;
    found       = 1'b0;
    grant       = 2'd0;
    idx         = 2'd0;
    grant_clr   = 4'b0000;

    // Round-robin scan starting one past the last served channel
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && pending[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end

    case (state)
      S_IDLE: begin
        if (found) begin
          grant_clr = 4'(4'b0001 << grant);
          sreg_n    = shadow[grant];
          last_n    = grant;
          state_n   = S_SETUP;
          cnt_n     = '0;
        end
      end
      S_SETUP: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          state_n     = S_SHIFT;
          cnt_n       = '0;
          bit_n       = '0;
          low_phase_n = 1'b0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          cnt_n = '0;
          if (!low_phase) begin
            low_phase_n = 1'b1;
          end else if (bit_idx == BIT_W'(WORD_W - 1)) begin
            state_n = S_HOLD;
          end else begin
            bit_n       = bit_idx + BIT_W'(1);
            low_phase_n = 1'b0;
            sreg_n      = {sreg[WORD_W-2:0], 1'b0};
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          state_n = S_GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == CNT_W'(GAP_CYC - 1)) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase

    // New request beats a same-cycle grant clear
    pending_n = (pending & ~grant_clr) | rise;

    fs_n   = !((state_n == S_SETUP) || (state_n == S_SHIFT));
    cs_n   = !((state_n == S_SETUP) || (state_n == S_SHIFT) || (state_n == S_HOLD));
    sclk_n = (state_n == S_SHIFT) && !low_phase_n;
    din_n  = ((state_n == S_SETUP) || (state_n == S_SHIFT)) ? sreg_n[WORD_W-1] : 1'b0;
    done_n = (state_n == S_GAP) && (cnt_n == CNT_W'(GAP_CYC - 1));
    busy_n = (state_n != S_IDLE) || (pending_n != 4'b0000);
  end

  // State, datapath and registered outputs with synchronous reset
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      low_phase  <= 1'b0;
      sreg       <= '0;
      last       <= 2'd3;
      pending    <= 4'b0000;
      trig_q     <= 4'b0000;
      Overrun    <= 4'b0000;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
      DAC_CLK    <= 1'b0;
      DAC_DIN    <= 1'b0;
      DAC_FS     <= 1'b1;
      DAC_CS     <= 1'b1;
      UpdateDone <= 1'b0;
      Done_Ch    <= 2'd0;
      Busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      low_phase  <= low_phase_n;
      sreg       <= sreg_n;
      last       <= last_n;
      pending    <= pending_n;
      trig_q     <= CH_TrSgn;
      Overrun    <= Overrun | (rise & pending);
      for (int i = 0; i < 4; i++) begin
        if (rise[i]) shadow[i] <= CH_Data[WORD_W*i +: WORD_W];
      end
      DAC_CLK    <= sclk_n;
      DAC_DIN    <= din_n;
      DAC_FS     <= fs_n;
      DAC_CS     <= cs_n;
      UpdateDone <= done_n;
      if (done_n) Done_Ch <= last_n;
      Busy       <= busy_n;
    end
  end

endmodule
